// File: rtl/apb_pkg.sv
// Shared types and constants for the APB RAM slave: FSM state encoding and
// response codes, plus a helper for the byte-lane address shift.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam logic APB_OKAY  = 1'b0;
  localparam logic APB_ERROR = 1'b1;

  // Number of low address bits that select a byte inside one data word.
  function automatic int lane_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_ram_array.sv
// Word-organised RAM with one byte-enabled synchronous write port and one
// read port whose output register is loaded on the APB setup edge.
module apb_ram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int NB         = DATA_WIDTH / 8,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]         wr_be,
  input  logic                  rd_load,
  input  logic                  rd_valid,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset branch; contents survive PRESET and
  // the array maps onto plain RAM cells instead of a bank of resettable flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read data is captured once per transfer and then held until the next setup.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_load) begin
      rd_data <= rd_valid ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/apb_ram_slave.sv
// APB slave fronting a word RAM with programmable wait states and address
// error decode. Define APB_RAM_PSTRB_EN to add the PSTRB byte-lane strobe port.
module apb_ram_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_RAM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = lane_bits(DATA_WIDTH);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0]            WAIT_LIM   = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);

  apb_state_t state, next_state;

  logic [3:0]            wait_cnt;
  logic [MEM_AW-1:0]     idx_q;
  logic                  write_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] idx_d;
  logic                  err_d;
  logic                  setup;
  logic                  wr_en;
  logic [NBYTES-1:0]     wr_be;

  // Decode is done on the live bus at setup; the ACCESS phase only uses the
  // latched copies.
  assign idx_d = PADDR >> LSB;
  assign err_d = ((PADDR & ALIGN_MASK) != '0) || (32'(idx_d) >= DEPTH);
  assign setup = (state == IDLE) && PSEL && !PENABLE;

  assign PREADY  = (state == ACCESS) && (wait_cnt == WAIT_LIM);
  assign PSLVERR = PREADY ? err_q : APB_OKAY;

  always_comb begin
    // NOTE: next_state gets its default before the case so every path assigns
    // it and no latch is inferred.
    next_state = state;
    case (state)
      IDLE:    if (setup) next_state = ACCESS;
      ACCESS:  if (PREADY || !PSEL) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (setup) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && PSEL && PENABLE && (wait_cnt < WAIT_LIM)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= APB_OKAY;
    end else if (setup) begin
      idx_q   <= MEM_AW'(idx_d);
      write_q <= PWRITE;
      err_q   <= err_d ? APB_ERROR : APB_OKAY;
    end
  end

  // Reset on the completion edge wins over the write.
  assign wr_en = !PRESET && PSEL && PENABLE && PWRITE && PREADY &&
                 write_q && (err_q == APB_OKAY);

`ifdef APB_RAM_PSTRB_EN
  assign wr_be = PSTRB;
`else
  assign wr_be = '1;
`endif

  apb_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .NB         (NBYTES),
    .AW         (MEM_AW)
  ) u_ram (
    .clk      (PCLK),
    .rst      (PRESET),
    .wr_en    (wr_en),
    .wr_addr  (idx_q),
    .wr_data  (PWDATA),
    .wr_be    (wr_be),
    .rd_load  (setup),
    .rd_valid (!err_d && !PWRITE),
    .rd_addr  (MEM_AW'(idx_d)),
    .rd_data  (PRDATA)
  );

endmodule
